gpu_fb_writer: RTL and testbench

// - Downstream of the gpu line rasteriser: consumes its pixel stream (x, y, r, g, b) and writes each pixel to the framebuffer memory.
// - Buffers pixels in a small FIFO so the rasteriser is not stalled by memory latency.
// - Linearises each coordinate to a framebuffer word address.
// - Clips pixels that fall off-screen.

---
 rtl/gpu_pkg.sv | 36 +++
 rtl/gpu_pix_fifo.sv | 66 ++++++
 rtl/gpu_fb_writer.sv | 176 +++++++++++++++++
 tb/tb_gpu_fb_writer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_pkg
//  Description : Shared types and constants for the framebuffer writer path
//                (pixel record, FIFO entry, writer FSM state encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  // Width of the address field carried in a FIFO entry. Widen this if the
  // writer is ever built with ADDR_W larger than 19.
  localparam int FB_ADDR_W = 19;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [23:0]          rgb;
  } fb_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fb_state_t;

endpackage
`default_nettype wire

// File: rtl/gpu_pix_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_pix_fifo
//  Description : Synchronous FIFO of framebuffer entries. Exposes the head and
//                the entry behind it so a consumer can reload on the same edge
//                it pops (back-to-back writes).
//  Revision    : 1.0 - initial release
// ============================================================================
module gpu_pix_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push,
  input  fb_entry_t                  din,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output fb_entry_t                  head,
  output fb_entry_t                  head_nxt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;

  // DEPTH is a power of two, so pointers wrap naturally.
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);
  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign head       = mem[rd_ptr];
  assign head_nxt   = mem[rd_ptr_inc];

  // Storage array: written on push, not reset (contents are qualified by count).
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr_inc;
      end
      count <= count + CNT_W'(push && !full) - CNT_W'(pop && !empty);
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpu_fb_writer.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_fb_writer
//  Description : Accepts the rasteriser pixel stream, clips off-screen pixels,
//                linearises coordinates to framebuffer word addresses, queues
//                them and issues held write requests to framebuffer memory.
//                Optional: define PIX_DEDUP_EN to drop a pixel identical to
//                the previous accepted on-screen pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpu_fb_writer
  import gpu_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int ADDR_W  = 19,
  parameter int FB_BASE = 0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              pix_valid_i,
  output logic              pix_ready_o,
  input  logic [9:0]        x_i,
  input  logic [8:0]        y_i,
  input  logic [7:0]        r_i,
  input  logic [7:0]        g_i,
  input  logic [7:0]        b_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [23:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  output logic              busy_o,
  output logic [15:0]       clip_cnt_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              accept;
  logic              on_screen;
  logic              is_dup;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [ADDR_W-1:0] lin_addr;
  fb_entry_t         push_entry;
  fb_entry_t         head;
  fb_entry_t         head_nxt;
  fb_state_t         state;
  fb_state_t         state_nxt;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [23:0]       wdata_d;

  assign accept    = pix_valid_i & pix_ready_o;
  assign on_screen = (32'(x_i) < H_RES) && (32'(y_i) < V_RES);

  // Address is fixed at push time so the FIFO holds ready-to-issue writes.
  assign lin_addr  = ADDR_W'(FB_BASE) + ADDR_W'(y_i) * ADDR_W'(H_RES) + ADDR_W'(x_i);
  assign push_entry.addr = FB_ADDR_W'(lin_addr);
  assign push_entry.rgb  = {r_i, g_i, b_i};

`ifdef PIX_DEDUP_EN
  pixel_t cur_pix;
  pixel_t last_pix;
  logic   last_vld;

  assign cur_pix = '{x: x_i, y: y_i, r: r_i, g: g_i, b: b_i};
  assign is_dup  = last_vld && (cur_pix == last_pix);

  // Remember the most recent accepted on-screen pixel for duplicate detection.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_pix <= '0;
      last_vld <= 1'b0;
    end else if (accept && on_screen) begin
      last_pix <= cur_pix;
      last_vld <= 1'b1;
    end
  end
`else
  assign is_dup = 1'b0;
`endif

  // The in-flight entry stays queued until acked, so it counts toward full.
  assign push       = accept & on_screen & ~is_dup & ~full;
  assign pop        = (state == REQ) & mem_ack_i;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  gpu_pix_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .n_rst    (n_rst),
    .push     (push),
    .din      (push_entry),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .head     (head),
    .head_nxt (head_nxt)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave IDLE on any queued entry, return once the last one is acked.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = REQ;
      REQ:     if (mem_ack_i && (count == CNT_W'(1))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next request outputs: load head on entry, reload the following entry on ack.
  always_comb begin
    we_d    = mem_we_o;
    addr_d  = mem_addr_o;
    wdata_d = mem_wdata_o;
    case (state)
      IDLE: begin
        if (!empty) begin
          we_d    = 1'b1;
          addr_d  = ADDR_W'(head.addr);
          wdata_d = head.rgb;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          if (count > CNT_W'(1)) begin
            addr_d  = ADDR_W'(head_nxt.addr);
            wdata_d = head_nxt.rgb;
          end else begin
            we_d = 1'b0;
          end
        end
      end
      default: we_d = 1'b0;
    endcase
  end

  // Registered outputs; ready and busy look ahead at next-cycle occupancy.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      busy_o      <= 1'b0;
      pix_ready_o <= 1'b0;
      clip_cnt_o  <= '0;
    end else begin
      mem_we_o    <= we_d;
      mem_addr_o  <= addr_d;
      mem_wdata_o <= wdata_d;
      busy_o      <= (count_next != '0) | we_d;
      pix_ready_o <= (count_next != CNT_W'(DEPTH));
      if (accept && !on_screen && (clip_cnt_o != 16'hFFFF)) begin
        clip_cnt_o <= clip_cnt_o + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gpu_fb_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpu_fb_writer
//  Description : Directed self-checking bench for gpu_fb_writer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_fb_writer;

  logic        clk;
  logic        n_rst;
  logic        pix_valid_i;
  logic        pix_ready_o;
  logic [9:0]  x_i;
  logic [8:0]  y_i;
  logic [7:0]  r_i, g_i, b_i;
  logic        mem_we_o;
  logic [18:0] mem_addr_o;
  logic [23:0] mem_wdata_o;
  logic        mem_ack_i;
  logic        busy_o;
  logic [15:0] clip_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  // Completed writes as {addr, data}.
  logic [42:0] wq [$];

  gpu_fb_writer u_dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .pix_valid_i (pix_valid_i),
    .pix_ready_o (pix_ready_o),
    .x_i         (x_i),
    .y_i         (y_i),
    .r_i         (r_i),
    .g_i         (g_i),
    .b_i         (b_i),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .busy_o      (busy_o),
    .clip_cnt_o  (clip_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture each acknowledged write.
  always @(posedge clk) begin
    if (n_rst && mem_we_o && mem_ack_i) wq.push_back({mem_addr_o, mem_wdata_o});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_pix(input logic [9:0] x, input logic [8:0] y,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int n;
    @(negedge clk);
    pix_valid_i = 1'b1;
    x_i = x; y_i = y; r_i = r; g_i = g; b_i = b;
    n = 0;
    while (!pix_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("push_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1 pix_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    mem_ack_i = 1'b1;
    n = 0;
    while ((busy_o || mem_we_o) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("drain_timeout", 64'(n), 64'd0);
    mem_ack_i = 1'b0;
  endtask

  initial begin
    int  we_hi;
    logic drop;
    logic [42:0] exp_e;

    n_rst = 1'b0; pix_valid_i = 1'b0; mem_ack_i = 1'b0;
    x_i = '0; y_i = '0; r_i = '0; g_i = '0; b_i = '0;

    // 1. Reset state
    #3;
    check("rst_we",    64'(mem_we_o),    64'd0);
    check("rst_addr",  64'(mem_addr_o),  64'd0);
    check("rst_wdata", 64'(mem_wdata_o), 64'd0);
    check("rst_busy",  64'(busy_o),      64'd0);
    check("rst_clip",  64'(clip_cnt_o),  64'd0);
    check("rst_ready", 64'(pix_ready_o), 64'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(pix_ready_o), 64'd1);
    check("post_rst_busy",  64'(busy_o),      64'd0);

    // 2. Single write, ack one cycle after we rises
    push_pix(10'd3, 9'd2, 8'hAA, 8'hBB, 8'hCC);
    @(negedge clk);
    check("t2_we_lat0", 64'(mem_we_o), 64'd0);
    check("t2_busy",    64'(busy_o),   64'd1);
    we_hi = 0;
    @(negedge clk);
    if (mem_we_o) we_hi++;
    check("t2_addr",  64'(mem_addr_o),  64'd1283);
    check("t2_wdata", 64'(mem_wdata_o), 64'hAABBCC);
    @(negedge clk);
    if (mem_we_o) we_hi++;
    mem_ack_i = 1'b1;
    @(negedge clk);
    if (mem_we_o) we_hi++;
    mem_ack_i = 1'b0;
    check("t2_we_cycles", 64'(we_hi), 64'd2);
    check("t2_busy_end",  64'(busy_o), 64'd0);
    check("t2_nwrites",   64'(wq.size()), 64'd1);
    wq.delete();

    // 3. Fill the FIFO with no ack, then drain back-to-back
    for (int i = 0; i < 8; i++) push_pix(10'(i), 9'd1, 8'(i), 8'h10, 8'h20);
    @(negedge clk);
    check("t3_ready_full", 64'(pix_ready_o), 64'd0);
    pix_valid_i = 1'b1; x_i = 10'd100; y_i = 9'd1;
    @(negedge clk);
    check("t3_ready_hold", 64'(pix_ready_o), 64'd0);
    pix_valid_i = 1'b0;
    mem_ack_i = 1'b1;
    drop = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 7 && !mem_we_o) drop = 1'b1;
    end
    mem_ack_i = 1'b0;
    check("t3_we_no_gap", 64'(drop),     64'd0);
    check("t3_we_end",    64'(mem_we_o), 64'd0);
    check("t3_busy_end",  64'(busy_o),   64'd0);
    check("t3_nwrites",   64'(wq.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      exp_e = {19'(640 + i), 8'(i), 8'h10, 8'h20};
      if (i < wq.size()) check($sformatf("t3_write%0d", i), 64'(wq[i]), 64'(exp_e));
    end
    wq.delete();

    // 4. Clipping boundaries and the last on-screen pixel
    push_pix(10'd640, 9'd0, 8'h01, 8'h02, 8'h03);
    push_pix(10'd0, 9'd480, 8'h01, 8'h02, 8'h03);
    @(negedge clk);
    check("t4_clip_cnt", 64'(clip_cnt_o), 64'd2);
    check("t4_we",       64'(mem_we_o),   64'd0);
    check("t4_busy",     64'(busy_o),     64'd0);
    push_pix(10'd639, 9'd479, 8'h12, 8'h34, 8'h56);
    drain();
    check("t4_nwrites", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) check("t4_corner", 64'(wq[0]), 64'({19'd307199, 24'h123456}));
    wq.delete();

    // 5. Reset asserted mid-request with three queued
    for (int i = 0; i < 3; i++) push_pix(10'(20 + i), 9'd7, 8'h55, 8'h66, 8'h77);
    @(negedge clk);
    check("t5_we_before", 64'(mem_we_o), 64'd1);
    #2 n_rst = 1'b0;
    #1;
    check("t5_we_async", 64'(mem_we_o), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("t5_busy",  64'(busy_o),      64'd0);
    check("t5_ready", 64'(pix_ready_o), 64'd1);
    check("t5_clip",  64'(clip_cnt_o),  64'd0);
    mem_ack_i = 1'b1;
    repeat (5) @(negedge clk);
    mem_ack_i = 1'b0;
    check("t5_no_stale", 64'(wq.size()), 64'd0);
    wq.delete();

    // 6. Identical pixel twice
    push_pix(10'd5, 9'd5, 8'h9A, 8'hBC, 8'hDE);
    push_pix(10'd5, 9'd5, 8'h9A, 8'hBC, 8'hDE);
    drain();
`ifdef PIX_DEDUP_EN
    check("t6_nwrites", 64'(wq.size()), 64'd1);
`else
    check("t6_nwrites", 64'(wq.size()), 64'd2);
`endif
    if (wq.size() > 0) check("t6_write", 64'(wq[0]), 64'({19'd3205, 24'h9ABCDE}));
    check("t6_clip", 64'(clip_cnt_o), 64'd0);
    wq.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
